// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IFU/LSU memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 256;
    localparam int TIMER_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between IFU and LSU. MEM_ARB_RR_EN switches simultaneous
// requests from fixed LSU priority to round-robin using a last_grant register.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   clk,
    input  logic   rst_n,
    input  logic   take,
`endif
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    output logic   grant_valid,
    output owner_t grant_owner
);

    assign grant_valid = ifu_valid || lsu_valid;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_owner = OWN_LSU;
        if (!lsu_valid) begin
            grant_owner = OWN_IFU;
        end else if (ifu_valid && (last_grant == OWN_LSU)) begin
            grant_owner = OWN_IFU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_IFU;
        end else if (take && grant_valid) begin
            last_grant <= grant_owner;
        end
    end
`else
    assign grant_owner = lsu_valid ? OWN_LSU : OWN_IFU;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory port arbiter for IFU and LSU with a timeout watchdog.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    state_t              state;
    owner_t              owner;
    logic [TIMER_W-1:0]  timer;
    logic                in_idle;
    logic                grant_valid;
    owner_t              grant_owner;
    logic                timed_out;
    logic                fire;
    logic [DATA_W-1:0]   fire_data;
    logic                fire_err;

    // rst_n gates ready so nothing looks accepted while reset is asserted.
    assign in_idle = rst_n && (state == ST_IDLE);

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .take        (in_idle),
`endif
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign ifu_req_ready = in_idle && grant_valid && (grant_owner == OWN_IFU);
    assign lsu_req_ready = in_idle && grant_valid && (grant_owner == OWN_LSU);

    // >= rather than == so an accept landing on the last cycle cannot leave WAIT unguarded.
    assign timed_out = (timer >= TIMER_LAST);

    always_comb begin
        fire      = 1'b0;
        fire_data = '0;
        fire_err  = 1'b0;
        if (state == ST_REQ) begin
            if (!mem_req_ready && timed_out) begin
                fire     = 1'b1;
                fire_err = 1'b1;
            end
        end else if (state == ST_WAIT) begin
            if (mem_rsp_valid) begin
                fire      = 1'b1;
                fire_data = mem_req_wen ? '0 : mem_rsp_data;
            end else if (timed_out) begin
                fire     = 1'b1;
                fire_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner         <= OWN_IFU;
            timer         <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            ifu_rsp_valid <= fire && (owner == OWN_IFU);
            ifu_rsp_data  <= (fire && (owner == OWN_IFU)) ? fire_data : '0;
            ifu_rsp_err   <= fire && (owner == OWN_IFU) && fire_err;
            lsu_rsp_valid <= fire && (owner == OWN_LSU);
            lsu_rsp_data  <= (fire && (owner == OWN_LSU)) ? fire_data : '0;
            lsu_rsp_err   <= fire && (owner == OWN_LSU) && fire_err;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_owner;
                        timer         <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= ST_REQ;
                        if (grant_owner == OWN_LSU) begin
                            mem_req_addr  <= lsu_req_addr;
                            mem_req_wen   <= lsu_req_wen;
                            mem_req_wdata <= lsu_req_wdata;
                            mem_req_wmask <= lsu_req_wmask;
                        end else begin
                            mem_req_addr  <= ifu_req_addr;
                            mem_req_wen   <= 1'b0;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    timer <= timer + 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end else if (fire) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (fire) begin
                        state <= ST_RESP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_data;
    logic          ifu_rsp_err;
    logic          lsu_req_valid, lsu_req_ready;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_wen;
    logic [DW-1:0] lsu_req_wdata;
    logic [MW-1:0] lsu_req_wmask;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_data;
    logic          lsu_rsp_err;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_wen;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;

    int checks = 0;
    int failures = 0;
    bit last_lsu = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: lone requester wins; a tie goes to LSU, or alternates under round-robin.
    function automatic bit pick_lsu(input bit iv, input bit lv);
`ifdef MEM_ARB_RR_EN
        if (iv && lv) return !last_lsu;
`endif
        return lv;
    endfunction

    // One complete transaction. Starts just after a rising edge in IDLE, ends just after
    // the rising edge that returns to IDLE. dr = REQ cycles before ready, dw = WAIT
    // cycles before the response; the model predicts a timeout once REQ+WAIT exceeds TMO.
    task automatic txn(input string tag, input bit iv, input bit lv,
                       input logic [AW-1:0] ia, input logic [AW-1:0] la, input bit lw,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm, input logic [DW-1:0] rd,
                       input int dr, input int dw, input bit respond, input bit spur);
        bit own_lsu, tmo;
        int done_i;
        logic [DW-1:0] exp_data;
        own_lsu = pick_lsu(iv, lv);
        tmo     = !respond || (dr + 1 + dw > TMO - 1);
        done_i  = tmo ? TMO - 1 : dr + 1 + dw;
        exp_data = tmo ? '0 : ((own_lsu && lw) ? '0 : rd);

        ifu_req_valid = iv;  ifu_req_addr  = ia;
        lsu_req_valid = lv;  lsu_req_addr  = la;
        lsu_req_wen   = lw;  lsu_req_wdata = wd;  lsu_req_wmask = wm;
        @(negedge clk);
        check({tag, "_ifu_ready"}, ifu_req_ready, iv && !own_lsu);
        check({tag, "_lsu_ready"}, lsu_req_ready, own_lsu);
        check({tag, "_idle_rsp"}, {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        @(posedge clk); #1;
        last_lsu = own_lsu;
        ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
        ifu_req_addr  = $urandom;  lsu_req_addr = $urandom;
        lsu_req_wdata = $urandom;  lsu_req_wmask = MW'($urandom);  lsu_req_wen = $urandom_range(0, 1);

        for (int i = 0; i <= done_i; i++) begin
            mem_req_ready = (i == dr);
            mem_rsp_valid = (!tmo && (i == dr + 1 + dw)) || (spur && (i <= dr));
            mem_rsp_data  = (i <= dr) ? DW'($urandom) : rd;
            @(negedge clk);
            check({tag, "_mem_valid"}, mem_req_valid, (i <= dr));
            if (i <= dr) begin
                check({tag, "_mem_addr"}, mem_req_addr, own_lsu ? la : ia);
                check({tag, "_mem_wen"}, mem_req_wen, own_lsu && lw);
                check({tag, "_mem_wdata"}, mem_req_wdata, own_lsu ? wd : '0);
                check({tag, "_mem_wmask"}, mem_req_wmask, own_lsu ? wm : '0);
            end
            check({tag, "_early_rsp"}, {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
            @(posedge clk); #1;
        end

        mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;
        ifu_req_valid = 1'b1;  lsu_req_valid = 1'b1;
        @(negedge clk);
        check({tag, "_resp_ready"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
        check({tag, "_resp_mem_valid"}, mem_req_valid, 1'b0);
        check({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, !own_lsu);
        check({tag, "_ifu_rsp_data"}, ifu_rsp_data, own_lsu ? '0 : exp_data);
        check({tag, "_ifu_rsp_err"}, ifu_rsp_err, !own_lsu && tmo);
        check({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, own_lsu);
        check({tag, "_lsu_rsp_data"}, lsu_rsp_data, own_lsu ? exp_data : '0);
        check({tag, "_lsu_rsp_err"}, lsu_rsp_err, own_lsu && tmo);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
    endtask

    initial begin
        int r;
        ifu_req_valid = 1'b1;  ifu_req_addr  = 32'h1234_5678;
        lsu_req_valid = 1'b1;  lsu_req_addr  = 32'h8765_4321;
        lsu_req_wen   = 1'b1;  lsu_req_wdata = 32'hFFFF_FFFF;  lsu_req_wmask = 4'hF;
        mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;  mem_rsp_data = '0;

        // Reset state, with both requesters already asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_fields", {mem_req_addr, mem_req_wdata}, '0);
        check("rst_mem_ctl", {mem_req_wen, mem_req_wmask}, '0);
        check("rst_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}, '0);
        check("rst_rsp_data", {ifu_rsp_data, lsu_rsp_data}, '0);
        ifu_req_valid = 1'b0;  lsu_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Minimum-latency IFU fetch, then a slow-ready LSU write.
        txn("ifu_rd", 1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0413, 0, 0, 1, 0);
        txn("lsu_wr", 0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'hCAFE_F00D, 3, 0, 1, 0);

        // Three back-to-back ties.
        for (int k = 0; k < 3; k++) begin
            txn("tie", 1, 1, 32'h8000_0100 + k, 32'h8000_2000 + k, 0, 32'h0, 4'h0, DW'($urandom), 0, 1, 1, 0);
        end

        // Memory never responds; a late response in IDLE must be dropped.
        txn("tmo_wait", 1, 0, 32'h8000_0200, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        mem_rsp_valid = 1'b1;  mem_rsp_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stray_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        end
        @(posedge clk); #1;
        txn("tmo_req", 0, 1, 32'h0, 32'h8000_0300, 0, 32'h0, 4'h0, 32'h0, 100, 0, 1, 0);

        // Asynchronous reset in the middle of WAIT.
        ifu_req_valid = 1'b1;  ifu_req_addr = 32'h8000_4000;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;  mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_valid", mem_req_valid, 1'b0);
        check("arst_mem_addr", mem_req_addr, '0);
        check("arst_rsp", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}, '0);
        last_lsu = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;  mem_rsp_data = 32'h1111_2222;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        end
        @(posedge clk); #1;
        txn("post_rst", 1, 0, 32'h8000_5000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0013, 0, 0, 1, 0);

        // Responses presented while still in REQ are ignored.
        txn("spur_req", 0, 1, 32'h0, 32'h8000_6000, 0, 32'h0, 4'h0, 32'h7777_8888, 2, 1, 1, 1);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(1, 3);
            txn("rand", r[0], r[1], AW'($urandom), AW'($urandom), bit'($urandom_range(0, 1)),
                DW'($urandom), MW'($urandom), DW'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 4),
                ($urandom_range(0, 9) != 0), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
